// File: rtl/x_mult18x18_accum.sv
// Frame accumulator for the 18x18 multiplier's 36-bit product stream.
// It sums LAST-delimited frames and presents each result on a valid/ready handshake.
module x_mult18x18_accum #(
    parameter int ACC_WIDTH = 48,
    parameter int MAX_TERMS = 256,
    parameter bit SATURATE  = 1'b0,
    localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 CE,
    input  logic                 CLR,
    input  logic [35:0]          P_IN,
    input  logic                 P_VALID,
    input  logic                 P_LAST,
    output logic                 P_READY,
    output logic [ACC_WIDTH-1:0] ACC,
    output logic                 ACC_VALID,
    input  logic                 ACC_READY,
    output logic                 OVF,
    output logic                 TRUNC,
    output logic [CNT_W-1:0]     COUNT
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    localparam logic [ACC_WIDTH-1:0] SUM_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SUM_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(MAX_TERMS);

    // Signed add overflow: equal operand signs with a result of the other sign.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   acc_valid_q, acc_valid_d;
    logic                   acc_ovf_q, acc_ovf_d;
    logic                   trunc_q, trunc_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   p_ready_s;
    logic                   accept_s;
    logic [ACC_WIDTH-1:0]   p_ext_s;
    logic [ACC_WIDTH-1:0]   base_sum_s;
    logic [CNT_W-1:0]       base_cnt_s;
    logic                   base_ovf_s;
    logic [ACC_WIDTH-1:0]   add_s;
    logic                   add_ovf_s;
    logic [ACC_WIDTH-1:0]   term_sum_s;
    logic [CNT_W-1:0]       term_cnt_s;
    logic                   cnt_hit_s;
    logic                   close_s;

    // Datapath for the term being offered; IDLE starts from a zero base.
    always_comb begin
        p_ready_s  = RSTN & CE & ~(acc_valid_q & ~ACC_READY);
        accept_s   = P_VALID & p_ready_s;
        p_ext_s    = {{(ACC_WIDTH-36){P_IN[35]}}, P_IN};
        if (state_q == ST_IDLE) begin
            base_sum_s = '0;
            base_cnt_s = '0;
            base_ovf_s = 1'b0;
        end else begin
            base_sum_s = sum_q;
            base_cnt_s = cnt_q;
            base_ovf_s = ovf_q;
        end
        add_s      = base_sum_s + p_ext_s;
        add_ovf_s  = add_ovf(base_sum_s[ACC_WIDTH-1], p_ext_s[ACC_WIDTH-1], add_s[ACC_WIDTH-1]);
        if (SATURATE && add_ovf_s) begin
            term_sum_s = base_sum_s[ACC_WIDTH-1] ? SUM_MIN : SUM_MAX;
        end else begin
            term_sum_s = add_s;
        end
        term_cnt_s = base_cnt_s + CNT_W'(1);
        cnt_hit_s  = (term_cnt_s == CNT_MAX);
        close_s    = accept_s & (P_LAST | cnt_hit_s);
    end

    // Next-state: frame FSM, running sum and result holding registers.
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        acc_d       = acc_q;
        acc_valid_d = acc_valid_q;
        acc_ovf_d   = acc_ovf_q;
        trunc_d     = trunc_q;
        count_d     = count_q;
        if (!CE) begin
            state_d = state_q;
        end else if (CLR) begin
            state_d     = ST_IDLE;
            sum_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            acc_valid_d = 1'b0;
        end else begin
            if (acc_valid_q && ACC_READY) begin
                acc_valid_d = 1'b0;
            end else begin
                acc_valid_d = acc_valid_q;
            end
            if (accept_s) begin
                sum_d = term_sum_s;
                cnt_d = term_cnt_s;
                ovf_d = base_ovf_s | add_ovf_s;
                case (close_s)
                    1'b1: begin
                        state_d     = ST_IDLE;
                        acc_d       = term_sum_s;
                        count_d     = term_cnt_s;
                        acc_ovf_d   = base_ovf_s | add_ovf_s;
                        trunc_d     = cnt_hit_s & ~P_LAST;
                        acc_valid_d = 1'b1;
                    end
                    default: state_d = ST_ACCUM;
                endcase
            end else begin
                state_d = state_q;
            end
        end
    end

    // State and result registers; CE gating lives in the next-state logic.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= ST_IDLE;
            sum_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
            acc_ovf_q   <= 1'b0;
            trunc_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
            acc_valid_q <= acc_valid_d;
            acc_ovf_q   <= acc_ovf_d;
            trunc_q     <= trunc_d;
            count_q     <= count_d;
        end
    end

    assign P_READY   = p_ready_s;
    assign ACC       = acc_q;
    assign ACC_VALID = acc_valid_q;
    assign OVF       = acc_ovf_q;
    assign TRUNC     = trunc_q;
    assign COUNT     = count_q;

endmodule
